// File: rtl/ts_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ts_pkg : training-sequence symbols, kinds, FSM states, helpers     |
// | rev 1.0 : initial release                                          |
// +------------------------------------------------------------------+
package ts_pkg;

    localparam logic [7:0] TS_COM = 8'hBC;
    localparam logic [7:0] TS1_ID = 8'h4A;
    localparam logic [7:0] TS2_ID = 8'h45;

    typedef enum logic [1:0] {
        TS_KIND_NONE = 2'b00,
        TS_KIND_TS1  = 2'b01,
        TS_KIND_TS2  = 2'b10
    } ts_kind_e;

    localparam int SYM_LINK = 1;
    localparam int SYM_LANE = 2;
    localparam int SYM_NFTS = 3;
    localparam int SYM_RATE = 4;
    localparam int SYM_CTRL = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LOCK = 2'd2
    } ts_state_e;

    function automatic logic [7:0] ts_sym(input logic [127:0] w, input int k);
        return w[8*k +: 8];
    endfunction

    // Returns TS_KIND_NONE for any malformed ordered set.
    function automatic ts_kind_e ts_classify(input logic [127:0] w);
        logic all1;
        logic all2;
        all1 = 1'b1;
        all2 = 1'b1;
        for (int k = 6; k < 16; k++) begin
            all1 = all1 & (w[8*k +: 8] == TS1_ID);
            all2 = all2 & (w[8*k +: 8] == TS2_ID);
        end
        if (w[7:0] != TS_COM) return TS_KIND_NONE;
        if (all1)             return TS_KIND_TS1;
        if (all2)             return TS_KIND_TS2;
        return TS_KIND_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ts_gap_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ts_gap_timer : GAP_MAX-cycle inactivity timer, one-cycle expiry    |
// | rev 1.0 : initial release                                          |
// +------------------------------------------------------------------+
module ts_gap_timer #(
    parameter int GAP_MAX = 1024,
    parameter int GAP_W   = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic hold_i,
    output logic expire_o
);

    if (GAP_MAX < 2) begin : g_chk_gap_min
        $error("ts_gap_timer: GAP_MAX must be >= 2");
    end
    if ((2 ** GAP_W) <= GAP_MAX) begin : g_chk_gap_w
        $error("ts_gap_timer: GAP_W too narrow for GAP_MAX");
    end

    localparam logic [GAP_W-1:0] c_last = GAP_W'(GAP_MAX - 1);

    logic [GAP_W-1:0] cnt_q;
    logic [GAP_W-1:0] cnt_d;

    // Expiry is the edge on which the count would reach GAP_MAX.
    always_comb begin
        expire_o = !restart_i && !hold_i && (cnt_q == c_last);
        cnt_d    = cnt_q + GAP_W'(1);
        if (restart_i || hold_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ts_rx_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ts_rx_decoder : per-lane TS1/TS2 validator, field extract, run cnt |
// | optional macro TS_RX_ERR_CNT_EN adds err_cnt; rev 1.0              |
// +------------------------------------------------------------------+
module ts_rx_decoder
    import ts_pkg::*;
#(
    parameter int CNT_TARGET = 8,
    parameter int CNT_W      = 4,
    parameter int GAP_MAX    = 1024,
    parameter int GAP_W      = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [127:0]       ts_i,
    input  logic               ts_i_vld,
    output logic [1:0]         ts_kind,
    output logic [7:0]         link_num,
    output logic [7:0]         lane_num,
    output logic [7:0]         n_fts,
    output logic [7:0]         rate_id,
    output logic [7:0]         train_ctl,
    output logic               ts_upd,
    output logic [CNT_W-1:0]   run_cnt,
    output logic               ts1_done,
    output logic               ts2_done,
    output logic               bad_ts,
    output logic               gap_to
`ifdef TS_RX_ERR_CNT_EN
    ,
    output logic [15:0]        err_cnt
`endif
);

    if ((2 ** CNT_W) - 1 < CNT_TARGET) begin : g_chk_cnt_w
        $error("ts_rx_decoder: CNT_W too narrow for CNT_TARGET");
    end

    localparam logic [CNT_W-1:0] c_cnt_tgt = CNT_W'(CNT_TARGET);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    ts_state_e         state_q, state_d;
    ts_kind_e          kind_q, kind_d;
    logic [5:1][7:0]   fld_q, fld_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              done1_q, done1_d;
    logic              done2_q, done2_d;
    logic              upd_q, upd_d;
    logic              bad_q, bad_d;
    logic              gap_q, gap_d;

    ts_kind_e          w_kind;
    logic [5:1][7:0]   w_fld;
    ts_state_e         w_state_base;
    logic [CNT_W-1:0]  w_cnt_base;
    logic              w_hit;
    logic              w_expire;

    ts_gap_timer #(
        .GAP_MAX (GAP_MAX),
        .GAP_W   (GAP_W)
    ) u_gap (
        .clk       (clk),
        .rst       (rst),
        .restart_i (ts_i_vld),
        .hold_i    (clr || (state_q == S_IDLE)),
        .expire_o  (w_expire)
    );

    always_comb begin
        w_kind = ts_classify(ts_i);
        for (int k = 1; k <= 5; k++) begin
            w_fld[k] = ts_sym(ts_i, k);
        end
    end

    // clr is folded in first so a same-cycle strobe is judged from S_IDLE.
    always_comb begin
        w_state_base = clr ? S_IDLE : state_q;
        w_cnt_base   = clr ? '0 : cnt_q;
        w_hit        = 1'b0;
        state_d      = w_state_base;
        cnt_d        = w_cnt_base;
        done1_d      = done1_q && !clr;
        done2_d      = done2_q && !clr;
        kind_d       = kind_q;
        fld_d        = fld_q;
        upd_d        = 1'b0;
        bad_d        = 1'b0;
        gap_d        = 1'b0;
        if (ts_i_vld) begin
            if (w_kind == TS_KIND_NONE) begin
                bad_d   = 1'b1;
                cnt_d   = '0;
                done1_d = 1'b0;
                done2_d = 1'b0;
                state_d = S_IDLE;
            end else begin
                upd_d = 1'b1;
                if (w_state_base != S_IDLE && w_kind == kind_q && w_fld == fld_q) begin
                    cnt_d = (w_cnt_base == c_cnt_max) ? w_cnt_base : w_cnt_base + CNT_W'(1);
                end else begin
                    cnt_d  = CNT_W'(1);
                    kind_d = w_kind;
                    fld_d  = w_fld;
                end
                w_hit   = (cnt_d >= c_cnt_tgt);
                done1_d = w_hit && (kind_d == TS_KIND_TS1);
                done2_d = w_hit && (kind_d == TS_KIND_TS2);
                state_d = w_hit ? S_LOCK : S_RUN;
            end
        end else if (w_expire) begin
            gap_d   = 1'b1;
            cnt_d   = '0;
            done1_d = 1'b0;
            done2_d = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            kind_q  <= TS_KIND_NONE;
            fld_q   <= '0;
            cnt_q   <= '0;
            done1_q <= 1'b0;
            done2_q <= 1'b0;
            upd_q   <= 1'b0;
            bad_q   <= 1'b0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            fld_q   <= fld_d;
            cnt_q   <= cnt_d;
            done1_q <= done1_d;
            done2_q <= done2_d;
            upd_q   <= upd_d;
            bad_q   <= bad_d;
            gap_q   <= gap_d;
        end
    end

`ifdef TS_RX_ERR_CNT_EN
    logic [15:0] err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= '0;
        end else if ((bad_d || gap_d) && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_cnt = err_q;
`endif

    assign ts_kind   = kind_q;
    assign link_num  = fld_q[SYM_LINK];
    assign lane_num  = fld_q[SYM_LANE];
    assign n_fts     = fld_q[SYM_NFTS];
    assign rate_id   = fld_q[SYM_RATE];
    assign train_ctl = fld_q[SYM_CTRL];
    assign ts_upd    = upd_q;
    assign run_cnt   = cnt_q;
    assign ts1_done  = done1_q;
    assign ts2_done  = done2_q;
    assign bad_ts    = bad_q;
    assign gap_to    = gap_q;

endmodule
`default_nettype wire

// File: tb/tb_ts_rx_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ts_rx_decoder : directed scoreboard bench for ts_rx_decoder     |
// | rev 1.0 : initial release                                          |
// +------------------------------------------------------------------+
module tb_ts_rx_decoder;

    localparam int GAP_MAX = 1024;
    localparam logic [7:0] NF = 8'h1F;
    localparam logic [7:0] RT = 8'h03;
    localparam logic [7:0] CT = 8'h08;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic [127:0] ts_i;
    logic         ts_i_vld;
    logic [1:0]   ts_kind;
    logic [7:0]   link_num, lane_num, n_fts, rate_id, train_ctl;
    logic         ts_upd, ts1_done, ts2_done, bad_ts, gap_to;
    logic [3:0]   run_cnt;
`ifdef TS_RX_ERR_CNT_EN
    logic [15:0]  err_cnt;
`endif

    ts_rx_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .ts_i      (ts_i),
        .ts_i_vld  (ts_i_vld),
        .ts_kind   (ts_kind),
        .link_num  (link_num),
        .lane_num  (lane_num),
        .n_fts     (n_fts),
        .rate_id   (rate_id),
        .train_ctl (train_ctl),
        .ts_upd    (ts_upd),
        .run_cnt   (run_cnt),
        .ts1_done  (ts1_done),
        .ts2_done  (ts2_done),
        .bad_ts    (bad_ts),
        .gap_to    (gap_to)
`ifdef TS_RX_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        upd;
        logic        bad;
        logic        gap;
        logic [1:0]  kind;
        logic [7:0]  link;
        logic [7:0]  lane;
        logic [23:0] fix;
        logic [3:0]  cnt;
        logic        d1;
        logic        d2;
        logic [15:0] err;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    n_gap = 0;
    exp_t  act_s, exp_s;
    string nm_s;

    function automatic logic [127:0] mk(input logic [7:0] c0, input logic [7:0] id,
                                        input logic [7:0] link, input logic [7:0] lane);
        logic [127:0] w;
        w         = '0;
        w[7:0]    = c0;
        w[15:8]   = link;
        w[23:16]  = lane;
        w[31:24]  = NF;
        w[39:32]  = RT;
        w[47:40]  = CT;
        for (int k = 6; k < 16; k++) w[8*k +: 8] = id;
        return w;
    endfunction

    task automatic expect_out(input string nm, input logic upd, input logic bad, input logic gap,
                              input logic [1:0] kind, input logic [7:0] link, input logic [7:0] lane,
                              input int cnt, input logic d1, input logic d2, input int err);
        exp_t e;
        e.upd  = upd;  e.bad  = bad;  e.gap = gap;
        e.kind = kind; e.link = link; e.lane = lane;
        e.fix  = {NF, RT, CT};
        e.cnt  = 4'(cnt);
        e.d1   = d1;   e.d2   = d2;
`ifdef TS_RX_ERR_CNT_EN
        e.err  = 16'(err);
`else
        e.err  = 16'(0 * err);
`endif
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic strobe(input logic [127:0] w, input logic with_clr);
        ts_i     = w;
        ts_i_vld = 1'b1;
        clr      = with_clr;
        @(negedge clk);
        ts_i_vld = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic ok, input int got, input int want);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, want);
        end
    endtask

    task automatic check_all_zero(input string nm);
        logic [79:0] v;
        v = {ts_kind, link_num, lane_num, n_fts, rate_id, train_ctl, ts_upd, run_cnt,
             ts1_done, ts2_done, bad_ts, gap_to};
`ifdef TS_RX_ERR_CNT_EN
        check({nm, "_err"}, err_cnt == 16'd0, int'(err_cnt), 0);
`endif
        n_cmp++;
        if (v !== '0) begin
            n_bad++;
            $display("FAIL %s: got outputs %h, expected all zero", nm, v);
        end
    endtask

    // Monitor: every output event pops one expectation.
    always @(negedge clk) begin
        if (rst && (ts_upd || bad_ts || gap_to)) begin
            if (gap_to) n_gap++;
            act_s.upd  = ts_upd;   act_s.bad  = bad_ts;   act_s.gap = gap_to;
            act_s.kind = ts_kind;  act_s.link = link_num; act_s.lane = lane_num;
            act_s.fix  = {n_fts, rate_id, train_ctl};
            act_s.cnt  = run_cnt;  act_s.d1   = ts1_done; act_s.d2  = ts2_done;
`ifdef TS_RX_ERR_CNT_EN
            act_s.err  = err_cnt;
`else
            act_s.err  = '0;
`endif
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got upd%0d bad%0d gap%0d cnt%0d, expected no event",
                         act_s.upd, act_s.bad, act_s.gap, act_s.cnt);
            end else begin
                exp_s = exp_q.pop_front();
                nm_s  = name_q.pop_front();
                if (act_s !== exp_s) begin
                    n_bad++;
                    $display("FAIL %s: got upd%0d bad%0d gap%0d kind%0d link%h lane%h fix%h cnt%0d d1%0d d2%0d err%0d, expected upd%0d bad%0d gap%0d kind%0d link%h lane%h fix%h cnt%0d d1%0d d2%0d err%0d",
                             nm_s, act_s.upd, act_s.bad, act_s.gap, act_s.kind, act_s.link, act_s.lane,
                             act_s.fix, act_s.cnt, act_s.d1, act_s.d2, act_s.err,
                             exp_s.upd, exp_s.bad, exp_s.gap, exp_s.kind, exp_s.link, exp_s.lane,
                             exp_s.fix, exp_s.cnt, exp_s.d1, exp_s.d2, exp_s.err);
                end
            end
        end
    end

    initial begin
        logic [127:0] w;
        rst = 1'b0; clr = 1'b0; ts_i_vld = 1'b0; ts_i = '0;
        idle(3);
        check_all_zero("reset_state");
        rst = 1'b1;
        idle(2);

        // 8 identical TS1 -> done on the 8th, then saturation at 15
        for (int i = 0; i < 8; i++) begin
            expect_out("ts1_run", 1, 0, 0, 2'b01, 8'h00, 8'h02, i + 1, i == 7, 0, 0);
            strobe(mk(8'hBC, 8'h4A, 8'h00, 8'h02), 1'b0);
            idle(9);
        end
        for (int j = 1; j <= 9; j++) begin
            expect_out("ts1_sat", 1, 0, 0, 2'b01, 8'h00, 8'h02, (8 + j > 15) ? 15 : 8 + j, 1, 0, 0);
            strobe(mk(8'hBC, 8'h4A, 8'h00, 8'h02), 1'b0);
            idle(2);
        end

        // lane change restarts the run
        for (int j = 1; j <= 4; j++) begin
            expect_out("lane_chg", 1, 0, 0, 2'b01, 8'h00, 8'h03, j, 0, 0, 0);
            strobe(mk(8'hBC, 8'h4A, 8'h00, 8'h03), 1'b0);
            idle(2);
        end

        // TS2 with same symbols 1..5 is a different kind
        for (int j = 1; j <= 9; j++) begin
            expect_out("ts2_run", 1, 0, 0, 2'b10, 8'h00, 8'h03, j, 0, j >= 8, 0);
            strobe(mk(8'hBC, 8'h45, 8'h00, 8'h03), 1'b0);
            idle(2);
        end

        // run of 5, then bad COM symbol
        for (int j = 1; j <= 5; j++) begin
            expect_out("pre_bad", 1, 0, 0, 2'b01, 8'h05, 8'h01, j, 0, 0, 0);
            strobe(mk(8'hBC, 8'h4A, 8'h05, 8'h01), 1'b0);
            idle(2);
        end
        expect_out("bad_com", 0, 1, 0, 2'b01, 8'h05, 8'h01, 0, 0, 0, 1);
        strobe(mk(8'h00, 8'h4A, 8'h05, 8'h01), 1'b0);
        idle(2);
        expect_out("after_bad", 1, 0, 0, 2'b01, 8'h05, 8'h01, 1, 0, 0, 1);
        strobe(mk(8'hBC, 8'h4A, 8'h05, 8'h01), 1'b0);
        idle(2);
        w = mk(8'hBC, 8'h4A, 8'h09, 8'h01);
        w[79:72] = 8'h4B;
        expect_out("bad_tail", 0, 1, 0, 2'b01, 8'h05, 8'h01, 0, 0, 0, 2);
        strobe(w, 1'b0);
        idle(2);

        // lock, then gap timeout
        for (int j = 1; j <= 8; j++) begin
            expect_out("pre_gap", 1, 0, 0, 2'b01, 8'h05, 8'h01, j, 0 || (j == 8), 0, 2);
            strobe(mk(8'hBC, 8'h4A, 8'h05, 8'h01), 1'b0);
            if (j < 8) idle(2);
        end
        expect_out("gap_to", 0, 0, 1, 2'b01, 8'h05, 8'h01, 0, 0, 0, 3);
        idle(GAP_MAX - 1);
        check("gap_not_early", n_gap == 0, n_gap, 0);
        idle(2);
        check("gap_once", n_gap == 1, n_gap, 1);
        idle(10);
        check("gap_no_repeat", n_gap == 1, n_gap, 1);

        // strobe on the expiry cycle suppresses the timeout
        expect_out("exp_a", 1, 0, 0, 2'b01, 8'h05, 8'h01, 1, 0, 0, 3);
        strobe(mk(8'hBC, 8'h4A, 8'h05, 8'h01), 1'b0);
        idle(GAP_MAX - 1);
        expect_out("exp_vld", 1, 0, 0, 2'b01, 8'h05, 8'h01, 2, 0, 0, 3);
        strobe(mk(8'hBC, 8'h4A, 8'h05, 8'h01), 1'b0);
        idle(3);
        check("exp_no_gap", n_gap == 1, n_gap, 1);

        // clr with and without a same-cycle strobe
        for (int j = 1; j <= 3; j++) begin
            expect_out("pre_clr", 1, 0, 0, 2'b10, 8'h07, 8'h00, j, 0, 0, 3);
            strobe(mk(8'hBC, 8'h45, 8'h07, 8'h00), 1'b0);
            idle(2);
        end
        expect_out("clr_vld", 1, 0, 0, 2'b10, 8'h07, 8'h00, 1, 0, 0, 3);
        strobe(mk(8'hBC, 8'h45, 8'h07, 8'h00), 1'b1);
        idle(2);
        expect_out("post_clr", 1, 0, 0, 2'b10, 8'h07, 8'h00, 2, 0, 0, 3);
        strobe(mk(8'hBC, 8'h45, 8'h07, 8'h00), 1'b0);
        idle(2);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        expect_out("clr_only", 1, 0, 0, 2'b10, 8'h07, 8'h00, 1, 0, 0, 3);
        strobe(mk(8'hBC, 8'h45, 8'h07, 8'h00), 1'b0);
        idle(2);

        // mid-run reset
        expect_out("pre_rst", 1, 0, 0, 2'b10, 8'h07, 8'h00, 2, 0, 0, 3);
        strobe(mk(8'hBC, 8'h45, 8'h07, 8'h00), 1'b0);
        idle(2);
        rst = 1'b0;
        idle(1);
        check_all_zero("mid_reset");
        rst = 1'b1;
        expect_out("post_rst", 1, 0, 0, 2'b10, 8'h07, 8'h00, 1, 0, 0, 0);
        strobe(mk(8'hBC, 8'h45, 8'h07, 8'h00), 1'b0);
        idle(5);

        check("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
        check("gap_total", n_gap == 1, n_gap, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ts_rx_decoder.md
Name: ts_rx_decoder

Overview:
- Per-lane receive-side training-sequence decoder. Consumes the 128-bit TS word and valid strobe that the link partner's LTSSM drives on its lane output.
- Validates each ordered set and extracts its fields.
- Counts consecutive identical TS1/TS2 and flags when the run target is reached.
- One instance per lane, between the lane TS input and the LTSSM Polling/Configuration exit logic.

Parameters:
- CNT_TARGET, 8, consecutive identical TS required to assert ts1_done/ts2_done.
- CNT_W, 4, width of run_cnt. Must satisfy 2^CNT_W-1 >= CNT_TARGET; elaboration error otherwise.
- GAP_MAX, 1024, cycles without ts_i_vld before the run is abandoned. Must be >= 2.
- GAP_W, 11, width of the gap counter. Must satisfy 2^GAP_W > GAP_MAX.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-low reset
- clr  in  1  synchronous run clear, pulsed by the LTSSM on state entry
- ts_i  in  128  TS word; symbol k occupies bits [8k+7:8k]
- ts_i_vld  in  1  single-cycle strobe, one per TS
- ts_kind  out  2  kind of last accepted TS: 00 none, 01 TS1, 10 TS2
- link_num  out  8  symbol 1 of last accepted TS
- lane_num  out  8  symbol 2
- n_fts  out  8  symbol 3
- rate_id  out  8  symbol 4
- train_ctl  out  8  symbol 5
- ts_upd  out  1  pulse: accepted TS processed this cycle
- run_cnt  out  CNT_W  consecutive identical count, saturating at all-ones
- ts1_done  out  1  level: TS1 run reached CNT_TARGET
- ts2_done  out  1  level: TS2 run reached CNT_TARGET
- bad_ts  out  1  pulse: malformed TS received
- gap_to  out  1  pulse: gap timeout fired

Behaviour:
- Reset (rst=0 at a clk edge) forces:
  - all outputs to 0, ts_kind=00;
  - FSM to S_IDLE;
  - gap counter to 0;
  - all stored fields to 0.
- A TS is well-formed when symbol0==8'hBC and symbols 6..15 all equal 8'h4A (TS1) or all equal 8'h45 (TS2). Any other value is malformed.
- Latency: all outputs are registered and update on the edge that samples ts_i_vld=1, so they are visible one cycle after the strobe.
- Malformed TS:
  - bad_ts=1 for one cycle;
  - run_cnt=0, ts1_done=ts2_done=0;
  - stored fields and ts_kind are unchanged;
  - FSM goes to S_IDLE.
- Well-formed TS:
  - ts_upd=1 for one cycle.
  - If FSM is not S_IDLE, and the kind plus symbols 1..5 equal the stored values: run_cnt = min(run_cnt+1, 2^CNT_W-1).
  - Otherwise: run_cnt=1, the fields and ts_kind are reloaded, and both done flags are cleared.
  - FSM goes to S_RUN, or to S_LOCK once the run count reaches CNT_TARGET.
- Done flags:
  - ts1_done is set on the same edge run_cnt reaches CNT_TARGET with ts_kind=01; ts2_done likewise with ts_kind=10.
  - Each stays set while identical TS continue to arrive.
- FSM states:
  - S_IDLE: no reference TS held.
  - S_RUN: 1 <= run_cnt < CNT_TARGET.
  - S_LOCK: target reached.
- Gap timer:
  - Counts while in S_RUN or S_LOCK; resets to 0 on every ts_i_vld.
  - When it reaches GAP_MAX: gap_to=1 for one cycle, run_cnt=0, done flags=0, FSM to S_IDLE. Stored fields are retained.
  - Held at 0 in S_IDLE.
- clr:
  - Sets run_cnt=0, done flags=0, FSM to S_IDLE, gap counter to 0.
  - Stored fields are retained.
  - If ts_i_vld arrives in the same cycle, clr applies first and the TS is then processed from S_IDLE. A well-formed TS gives run_cnt=1.
- Priority: rst > clr > ts_i_vld > gap timeout. A vld on the timeout cycle suppresses gap_to.
- ts_i is ignored when ts_i_vld=0. Back-to-back strobes on consecutive cycles are supported.

Optional Feature:
- Macro: TS_RX_ERR_CNT_EN.
- When defined, adds output err_cnt (16 bits):
  - saturating count of malformed TS plus gap timeouts;
  - cleared by rst only, not by clr;
  - updates on the same edge as the bad_ts/gap_to pulse.
- When undefined: the port is absent and no counter logic is built.

Decomposition:
- Shared package ts_pkg holds:
  - TS_COM=8'hBC, TS1_ID=8'h4A, TS2_ID=8'h45;
  - kind encodings TS_KIND_NONE/TS1/TS2;
  - symbol index constants SYM_LINK=1, SYM_LANE=2, SYM_NFTS=3, SYM_RATE=4, SYM_CTRL=5;
  - FSM state encodings.
- One sub-module: ts_gap_timer, the GAP_MAX counter with restart/hold/expire pulse. The LTSSM-side TS encoder reuses it.

Test Plan:
- 8 identical TS1 (link 00, lane 02, symbols 6..15 = 4A) at 10-cycle spacing: run_cnt steps 1..8; ts1_done=1 one cycle after the 8th strobe; FSM in S_LOCK.
- 4 TS1 with lane=02, then a TS1 with lane=03: run_cnt=1, lane_num=03, ts1_done=0.
- Well-formed TS1 then TS2 with identical symbols 1..5: run_cnt=1, ts_kind=10; 8 more TS2: ts2_done=1, ts1_done=0.
- TS with symbol0=00 after a run of 5: bad_ts pulses once; run_cnt=0; link_num unchanged; with TS_RX_ERR_CNT_EN, err_cnt=1.
- In S_LOCK, no strobe for GAP_MAX cycles: gap_to pulses exactly once; done flags=0; run_cnt=0. A strobe on the expiry cycle gives no gap_to and run_cnt+1.
- Both cases end with run_cnt=1, ts2_done=0 and no gap_to:
  - clr and well-formed TS2 strobe in the same cycle mid-run.
  - rst=0 for one cycle mid-run, then the same TS2: all outputs read 0 after the reset edge.
